br_ctrl: RTL and testbench

BR_CTRL -- requirements
Module: br_ctrl

---
 rtl/br_pkg.sv | 9 +
 rtl/rr_arb2.sv | 42 ++++
 rtl/br_ctrl.sv | 141 ++++++++++++++
 tb/tb_br_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared widths, requester IDs and sweep-state encoding for the register-bank write controller.
package br_pkg;
  localparam int NREG_DEF = 32;
  localparam int AW       = 5;
  localparam int DW       = 32;

  typedef enum logic {REQ_ALU = 1'b0, REQ_MEM = 1'b1} req_id_e;
  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with one-hot grants; the pointer moves only on a grant.
module rr_arb2
  import br_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e last_r;

  // Grant selection: a lone requester wins, contention goes to the one not served last
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_r == REQ_MEM) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

  // Round-robin pointer; reset value makes ALU the favoured requester
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= REQ_MEM;
    end else if (gnt[0]) begin
      last_r <= REQ_ALU;
    end else if (gnt[1]) begin
      last_r <= REQ_MEM;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/br_ctrl.sv
// Register-bank write-port controller: arbitrates ALU and load writebacks onto one write port.
// Optional post-reset zeroing sweep of the bank is built only when BR_CLEAR_EN is defined.
module br_ctrl
  import br_pkg::*;
#(
  parameter int NREG = NREG_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  output logic          regWrite,
  output logic [AW-1:0] a3,
  output logic [DW-1:0] wd3,
  output logic          busy
);

  if (NREG < 1 || NREG > (1 << AW)) begin : g_nreg_range
    $error("br_ctrl: NREG must lie in 1..32");
  end

  logic          run_s;
  logic          clear_wr_s;
  logic [AW-1:0] clr_addr_s;
  logic [1:0]    gnt_s;
  logic [AW-1:0] sel_rd_s;
  logic [DW-1:0] sel_data_s;
  logic          reg_write_r;
  logic [AW-1:0] a3_r;
  logic [DW-1:0] wd3_r;

`ifdef BR_CLEAR_EN
  localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

  state_e        state_r;
  logic [AW-1:0] cnt_r;
  logic          busy_r;

  // Sweep FSM; busy_r tracks the cycles whose registered write is a sweep write
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_CLEAR;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          busy_r <= 1'b1;
          if (cnt_r == LAST_ADDR) begin
            state_r <= ST_RUN;
            cnt_r   <= cnt_r;
          end else begin
            state_r <= ST_CLEAR;
            cnt_r   <= cnt_r + AW'(1);
          end
        end
        ST_RUN: begin
          busy_r  <= 1'b0;
          state_r <= ST_RUN;
          cnt_r   <= cnt_r;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_CLEAR;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign clear_wr_s = (state_r == ST_CLEAR);
  assign clr_addr_s = cnt_r;
  // Hold off requesters while the final sweep write is still on the port
  assign run_s      = (state_r == ST_RUN) && !busy_r && !rst;
  assign busy       = busy_r;
`else
  assign clear_wr_s = 1'b0;
  assign clr_addr_s = '0;
  assign run_s      = !rst;
  assign busy       = 1'b0;
`endif

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (run_s),
    .req ({mem_valid, alu_valid}),
    .gnt (gnt_s)
  );

  assign alu_ready = gnt_s[0];
  assign mem_ready = gnt_s[1];

  // Route the granted requester's destination and data toward the write port
  always_comb begin
    sel_rd_s   = '0;
    sel_data_s = '0;
    if (gnt_s[1]) begin
      sel_rd_s   = mem_rd;
      sel_data_s = mem_data;
    end else if (gnt_s[0]) begin
      sel_rd_s   = alu_rd;
      sel_data_s = alu_data;
    end else begin
      sel_rd_s   = '0;
      sel_data_s = '0;
    end
  end

  // Registered write port; accepted x0 writes leave the port idle and a3/wd3 unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_r <= 1'b0;
      a3_r        <= '0;
      wd3_r       <= '0;
    end else if (clear_wr_s) begin
      reg_write_r <= 1'b1;
      a3_r        <= clr_addr_s;
      wd3_r       <= '0;
    end else if ((|gnt_s) && (sel_rd_s != '0)) begin
      reg_write_r <= 1'b1;
      a3_r        <= sel_rd_s;
      wd3_r       <= sel_data_s;
    end else begin
      reg_write_r <= 1'b0;
      a3_r        <= a3_r;
      wd3_r       <= wd3_r;
    end
  end

  assign regWrite = reg_write_r;
  assign a3       = a3_r;
  assign wd3      = wd3_r;

endmodule

// File: tb/tb_br_ctrl.sv
// Self-checking bench for br_ctrl: directed scenarios plus randomized traffic against a
// round-robin reference model. Covers the clear sweep when BR_CLEAR_EN is defined.
module tb_br_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = 5'd0;
  logic [31:0] alu_data = 32'd0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = 5'd0;
  logic [31:0] mem_data = 32'd0;
  logic        mem_ready;
  logic        regWrite;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  // reference model: who was served last, and what the write port should show
  bit          m_last_mem = 1'b1;
  bit          m_rw = 1'b0;
  logic [4:0]  m_a3 = 5'd0;
  logic [31:0] m_wd3 = 32'd0;
  bit          acc_alu, acc_mem;

  br_ctrl #(.NREG(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .regWrite(regWrite), .a3(a3), .wd3(wd3), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One RUN-mode cycle: predict and check readys, then the registered write one cycle later
  task automatic run_cycle();
    bit ea, em;
    #1;
    ea = 1'b0; em = 1'b0;
    if (alu_valid && mem_valid) begin
      if (m_last_mem) ea = 1'b1; else em = 1'b1;
    end else if (alu_valid) ea = 1'b1;
    else if (mem_valid) em = 1'b1;
    check("alu_ready", alu_ready, ea);
    check("mem_ready", mem_ready, em);
    @(posedge clk);
    m_rw = 1'b0;
    if (ea) begin
      m_last_mem = 1'b0;
      if (alu_rd != 5'd0) begin m_rw = 1'b1; m_a3 = alu_rd; m_wd3 = alu_data; end
    end else if (em) begin
      m_last_mem = 1'b1;
      if (mem_rd != 5'd0) begin m_rw = 1'b1; m_a3 = mem_rd; m_wd3 = mem_data; end
    end
    acc_alu = ea; acc_mem = em;
    @(negedge clk);
    check("regWrite", regWrite, m_rw);
    check("a3", a3, m_a3);
    check("wd3", wd3, m_wd3);
    check("busy_run", busy, 1'b0);
  endtask

`ifdef BR_CLEAR_EN
  // Called just after rst is released at a negedge; requesters stay valid to prove readys are held off
  task automatic sweep_check();
    int n;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hAAAA_0009;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'hBBBB_0004;
    n = 0;
    while (busy !== 1'b1 && n < 5) begin @(negedge clk); n++; end
    check("sweep_start", busy, 1'b1);
    for (int i = 0; i < 32; i++) begin
      check("sweep_busy", busy, 1'b1);
      check("sweep_we", regWrite, 1'b1);
      check("sweep_a3", a3, i);
      check("sweep_wd3", wd3, 32'd0);
      check("sweep_alu_rdy", alu_ready, 1'b0);
      check("sweep_mem_rdy", mem_ready, 1'b0);
      if (i == 31) begin alu_valid = 1'b0; mem_valid = 1'b0; end
      @(negedge clk);
    end
    check("sweep_done_busy", busy, 1'b0);
    check("sweep_done_we", regWrite, 1'b0);
  endtask
`endif

  initial begin
    bit pa, pm;
    int n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_we", regWrite, 1'b0);
    check("rst_a3", a3, 5'd0);
    check("rst_wd3", wd3, 32'd0);
    check("rst_busy", busy, 1'b0);

`ifdef BR_CLEAR_EN
    rst = 1'b0;
    sweep_check();
    // reset in the middle of a sweep restarts it at address 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 5) begin @(negedge clk); n++; end
    n = 0;
    while (a3 !== 5'd10 && n < 40) begin @(negedge clk); n++; end
    check("mid_sweep_reach10", a3, 5'd10);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_we", regWrite, 1'b0);
    check("mid_rst_a3", a3, 5'd0);
    rst = 1'b0;
    sweep_check();
    m_last_mem = 1'b1; m_rw = 1'b0; m_a3 = 5'd31; m_wd3 = 32'd0;
`else
    // a transfer presented during reset is dropped; the same request is taken right after release
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hCAFE_0003;
    #1 check("rst_cycle_alu_rdy", alu_ready, 1'b0);
    @(negedge clk);
    check("rst_cycle_no_write", regWrite, 1'b0);
    rst = 1'b0;
    run_cycle();
    check("first_cycle_accept", acc_alu, 1'b1);
    alu_valid = 1'b0;
`endif

    // lone ALU writeback
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
    run_cycle();
    alu_valid = 1'b0;
    run_cycle();
    check("alu_single_wd3", wd3, 32'h0000_1234);

    // load to x0: accepted, never written
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h0000_FFFF;
    run_cycle();
    check("x0_accepted", acc_mem, 1'b1);
    check("x0_no_write", regWrite, 1'b0);
    mem_valid = 1'b0;

    // sustained contention alternates ALU, MEM, ALU, MEM
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1111_0001;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h2222_0002;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      check("alt_a3", a3, (i % 2 == 0) ? 5'd1 : 5'd2);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    run_cycle();

    // same destination from both: two writes in grant order, later one remains
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777_000A;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h7777_000B;
    n = 0;
    while ((alu_valid || mem_valid) && n < 4) begin
      run_cycle();
      if (acc_alu) alu_valid = 1'b0;
      if (acc_mem) mem_valid = 1'b0;
      n++;
    end
    check("same_rd_both_done", {alu_valid, mem_valid}, 2'b00);
    run_cycle();
    check("same_rd_a3", a3, 5'd7);

    // randomized traffic; requesters hold until accepted
    pa = 1'b0; pm = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pa && $urandom_range(0, 9) < 6) begin
        pa = 1'b1; alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
      end
      if (!pm && $urandom_range(0, 9) < 6) begin
        pm = 1'b1; mem_rd = 5'($urandom_range(0, 31)); mem_data = $urandom;
      end
      alu_valid = pa; mem_valid = pm;
      run_cycle();
      if (acc_alu) pa = 1'b0;
      if (acc_mem) pm = 1'b0;
    end
    alu_valid = 1'b0; mem_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
